// File: rtl/seg_display_pkg.sv
// Shared definitions for the 7-segment display driver: FSM states, the blank code and the hex glyph table.
// Glyphs are gfedcba ordered and active-low.
package seg_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Index n holds the glyph for nibble n (0-9, then A b C d E F).
  localparam logic [15:0][6:0] GLYPH_ROM = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/seg7_glyph.sv
// Maps one nibble to its active-low 7-segment glyph.
// Latency: combinational. Backpressure: none, pure lookup.
module seg7_glyph
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = GLYPH_ROM[nibble];

endmodule

// File: rtl/seg_display_driver.sv
// Binary to multi-digit 7-segment driver, hex or double-dabble decimal; SEG_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: outputs update 2 edges after accept (hex, accept edge included) or WIDTH+2 edges (decimal).
// Backpressure: in_ready high only in IDLE; in_valid while busy is dropped, nothing is queued.
module seg_display_driver
  import seg_display_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_value,
  input  logic                  in_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7*DIGITS-1:0]   segments,
  output logic                  done,
  output logic                  overflow
);

  localparam int BCDW = 4 * DIGITS;
  localparam int EXTW = (WIDTH > BCDW) ? WIDTH : BCDW;
  localparam int CNTW = $clog2(WIDTH + 1);

  state_t               state;
  state_t               stateNext;
  logic                 accept;
  logic [WIDTH-1:0]     shiftReg;
  logic [BCDW-1:0]      bcdReg;
  logic                 carryReg;
  logic [CNTW-1:0]      bitCnt;
  logic [EXTW-1:0]      valExt;
  logic                 hexOvf;
  logic [BCDW-1:0]      adjusted;
  logic [BCDW-1:0]      dabbleNext;
  logic                 dabbleCarry;
  logic [DIGITS-1:0]    digitBlank;
  logic [7*DIGITS-1:0]  segNext;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    in_ready  = (state == IDLE);
    accept    = in_valid && in_ready;
    case (state)
      IDLE:    if (accept) stateNext = in_mode ? CONV : LATCH;
      CONV:    if (bitCnt == CNTW'(WIDTH - 1)) stateNext = LATCH;
      LATCH:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Hex digits are taken straight from the input; bits above the shown digits flag overflow.
  assign valExt = EXTW'(in_value);
  assign hexOvf = (valExt >> BCDW) != '0;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  always_comb begin
    adjusted = bcdReg;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcdReg[4*d +: 4] >= 4'd5) adjusted[4*d +: 4] = bcdReg[4*d +: 4] + 4'd3;
    end
    {dabbleCarry, dabbleNext} = {adjusted, shiftReg[WIDTH-1]};
  end

  always_comb begin
    digitBlank = '0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    begin : leadingZero
      logic seenNz;
      seenNz = 1'b0;
      for (int d = DIGITS - 1; d > 0; d--) begin
        seenNz        = seenNz | (bcdReg[4*d +: 4] != 4'd0);
        digitBlank[d] = !seenNz;
      end
    end
`endif
  end

  for (genvar g = 0; g < DIGITS; g++) begin : gDigit
    logic [6:0] glyph;
    seg7_glyph uGlyph (
      .nibble (bcdReg[4*g +: 4]),
      .pattern(glyph)
    );
    assign segNext[7*g +: 7] = digitBlank[g] ? SEG_BLANK : glyph;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shiftReg <= '0;
      bcdReg   <= '0;
      carryReg <= 1'b0;
      bitCnt   <= '0;
      segments <= {DIGITS{SEG_BLANK}};
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bitCnt <= '0;
            if (in_mode) begin
              shiftReg <= in_value;
              bcdReg   <= '0;
              carryReg <= 1'b0;
            end else begin
              bcdReg   <= valExt[BCDW-1:0];
              carryReg <= hexOvf;
            end
          end
        end
        CONV: begin
          shiftReg <= shiftReg << 1;
          bcdReg   <= dabbleNext;
          carryReg <= carryReg | dabbleCarry;
          bitCnt   <= bitCnt + 1'b1;
        end
        LATCH: begin
          segments <= segNext;
          overflow <= carryReg;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Bench for seg_display_driver: a 3-digit and a 2-digit instance share stimulus and are checked
// against an arithmetic model of the displayed digits, overflow and accept timing.
module tb_seg_display_driver;

  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_value;
  logic        in_mode;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [20:0] segments;
  logic [13:0] segments2;
  logic        done, done2;
  logic        overflow, overflow2;

  int checks   = 0;
  int failures = 0;

  seg_display_driver #(.WIDTH(WIDTH), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_value(in_value), .in_mode(in_mode), .in_valid(in_valid),
    .in_ready(in_ready), .segments(segments), .done(done), .overflow(overflow)
  );

  seg_display_driver #(.WIDTH(WIDTH), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_value(in_value), .in_mode(in_mode), .in_valid(in_valid),
    .in_ready(in_ready2), .segments(segments2), .done(done2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;  6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
     12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  function automatic int digit_range(input bit dec, input int nd);
    int m = 1;
    for (int i = 0; i < nd; i++) m *= (dec ? 10 : 16);
    return m;
  endfunction

  function automatic logic [34:0] exp_seg(input int v, input bit dec, input int nd);
    int base, num, p;
    logic [34:0] r;
    base = dec ? 10 : 16;
    num  = v % digit_range(dec, nd);
    r    = '1;
    p    = 1;
    for (int i = 0; i < nd; i++) begin
      r[7*i +: 7] = glyph((num / p) % base);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (i > 0 && (num / p) == 0) r[7*i +: 7] = 7'b1111111;
`endif
      p *= base;
    end
    return r;
  endfunction

  function automatic logic exp_ovf(input int v, input bit dec, input int nd);
    return (v >= digit_range(dec, nd)) ? 1'b1 : 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one value, keep random junk on the inputs while busy, then check the result.
  task automatic run_one(input logic [7:0] v, input bit m);
    logic [20:0] prevSeg;
    logic [13:0] prevSeg2;
    logic [34:0] e3, e2;
    int lat;
    lat = m ? WIDTH + 1 : 1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL run_ready_pre v=%0d m=%0d: in_ready=%b expected 1", v, m, in_ready);
    end
    prevSeg  = segments;
    prevSeg2 = segments2;
    in_value = v; in_mode = m; in_valid = 1'b1;
    step();
    for (int k = 1; k <= lat; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_value = 8'($urandom_range(0, 255));
      in_mode  = 1'($urandom_range(0, 1));
      checks++;
      if (in_ready !== 1'b0) begin
        failures++; $display("FAIL busy_ready v=%0d k=%0d: in_ready=%b expected 0", v, k, in_ready);
      end
      checks++;
      if (done !== 1'b0 || segments !== prevSeg || segments2 !== prevSeg2) begin
        failures++;
        $display("FAIL hold v=%0d k=%0d: done=%b seg=%b seg2=%b expected done=0 seg=%b seg2=%b",
                 v, k, done, segments, segments2, prevSeg, prevSeg2);
      end
      step();
    end
    in_valid = 1'b0;
    e3 = exp_seg(v, m, 3);
    e2 = exp_seg(v, m, 2);
    checks++;
    if (done !== 1'b1 || done2 !== 1'b1) begin
      failures++; $display("FAIL done_pulse v=%0d m=%0d: done=%b done2=%b expected 1", v, m, done, done2);
    end
    checks++;
    if (segments !== e3[20:0]) begin
      failures++; $display("FAIL seg3 v=%0d m=%0d: got %b expected %b", v, m, segments, e3[20:0]);
    end
    checks++;
    if (overflow !== exp_ovf(v, m, 3)) begin
      failures++; $display("FAIL ovf3 v=%0d m=%0d: got %b expected %b", v, m, overflow, exp_ovf(v, m, 3));
    end
    checks++;
    if (segments2 !== e2[13:0]) begin
      failures++; $display("FAIL seg2 v=%0d m=%0d: got %b expected %b", v, m, segments2, e2[13:0]);
    end
    checks++;
    if (overflow2 !== exp_ovf(v, m, 2)) begin
      failures++; $display("FAIL ovf2 v=%0d m=%0d: got %b expected %b", v, m, overflow2, exp_ovf(v, m, 2));
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL ready_after v=%0d: in_ready=%b expected 1", v, in_ready);
    end
    step();
    checks++;
    if (done !== 1'b0 || done2 !== 1'b0) begin
      failures++; $display("FAIL done_width v=%0d: done=%b done2=%b expected 0", v, done, done2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_value = 8'h5A; in_mode = 1'b0;
    repeat (2) step();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (segments !== {21{1'b1}} || segments2 !== {14{1'b1}}) begin
      failures++; $display("FAIL reset_seg: seg=%b seg2=%b expected all ones", segments, segments2);
    end
    checks++;
    if (done !== 1'b0 || overflow !== 1'b0 || overflow2 !== 1'b0) begin
      failures++; $display("FAIL reset_flags: done=%b ovf=%b ovf2=%b expected 0", done, overflow, overflow2);
    end
    checks++;
    if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin
      failures++; $display("FAIL reset_ready: in_ready=%b in_ready2=%b expected 1", in_ready, in_ready2);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL reset_priority: in_ready=%b done=%b expected 1/0", in_ready, done);
    end
  endtask

  task automatic test_directed();
    run_one(8'd255, 1'b1);
    run_one(8'hA5,  1'b0);
    run_one(8'd100, 1'b1);
    run_one(8'd0,   1'b1);
    run_one(8'd0,   1'b0);
    run_one(8'd99,  1'b1);
    run_one(8'hFF,  1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 2)) step();
      run_one(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_conv();
    logic sawDone;
    run_one(8'd200, 1'b1);
    in_value = 8'd123; in_mode = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1; in_valid = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (segments !== {21{1'b1}} || segments2 !== {14{1'b1}}) begin
      failures++; $display("FAIL abort_seg: seg=%b seg2=%b expected all ones", segments, segments2);
    end
    checks++;
    if (done !== 1'b0 || overflow2 !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL abort_state: done=%b ovf2=%b in_ready=%b expected 0/0/1", done, overflow2, in_ready);
    end
    sawDone = 1'b0;
    for (int k = 0; k < WIDTH + 4; k++) begin
      step();
      sawDone = sawDone | done | done2;
    end
    checks++;
    if (sawDone !== 1'b0) begin
      failures++; $display("FAIL abort_no_done: saw done=%b expected 0", sawDone);
    end
  endtask

  task automatic test_back_to_back();
    int busy;
    bit pend, acc;
    logic expRdy;
    logic [7:0] v, pendVal;
    logic [34:0] e;
    busy = 0; pend = 1'b0; pendVal = '0;
    for (int n = 0; n < 15; n++) begin
      v = (n % 2 == 1) ? 8'h34 : 8'h12;
      in_value = v; in_mode = 1'b0; in_valid = (n < 12);
      expRdy = (busy == 0);
      checks++;
      if (in_ready !== expRdy) begin
        failures++; $display("FAIL b2b_ready n=%0d: in_ready=%b expected %b", n, in_ready, expRdy);
      end
      acc = in_valid && (busy == 0);
      step();
      checks++;
      if (done !== pend) begin
        failures++; $display("FAIL b2b_done n=%0d: done=%b expected %b", n, done, pend);
      end
      if (pend) begin
        e = exp_seg(pendVal, 1'b0, 3);
        checks++;
        if (segments !== e[20:0]) begin
          failures++; $display("FAIL b2b_seg n=%0d: got %b expected %b", n, segments, e[20:0]);
        end
      end
      pend = acc; pendVal = v;
      if (acc) busy = 1;
      else if (busy > 0) busy--;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_value = '0; in_mode = 1'b0; in_valid = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_conv();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
